// File: rtl/pc_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_control_unit_if
// Brief    : Bus bundle between the datapath and the PC / next-address unit.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_control_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              stall;
    logic              zero_flag;
    logic [ADDR_W-1:0] rs_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              link_we;
    logic [4:0]        link_addr;
    logic [ADDR_W-1:0] link_data;
    logic              redirect;
    logic              slot_err;
    logic [CNT_W-1:0]  taken_cnt;

    // Datapath side: supplies the instruction stream and operand data.
    modport master (
        output instr, instr_valid, stall, zero_flag, rs_data,
        input  pc, pc_plus4, link_we, link_addr, link_data,
               redirect, slot_err, taken_cnt
    );

    // PC unit side.
    modport slave (
        input  instr, instr_valid, stall, zero_flag, rs_data,
        output pc, pc_plus4, link_we, link_addr, link_data,
               redirect, slot_err, taken_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_control_unit
// Brief    : Registered PC / next-address unit resolving J, JAL, JR, BEQ, BNE
//            with optional branch-delay-slot mode and $31 link generation.
// Revision : 1.0 - initial release
// ============================================================================
module pc_control_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                DELAY_SLOT = 0,
    parameter int                CNT_W      = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pc_control_unit_if.slave  bus
);

    localparam logic [5:0]        c_OP_SPECIAL = 6'd0;
    localparam logic [5:0]        c_OP_J       = 6'd2;
    localparam logic [5:0]        c_OP_JAL     = 6'd3;
    localparam logic [5:0]        c_OP_BEQ     = 6'd4;
    localparam logic [5:0]        c_OP_BNE     = 6'd5;
    localparam logic [5:0]        c_FUNCT_JR   = 6'd8;
    localparam logic [ADDR_W-1:0] c_FOUR       = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_EIGHT      = ADDR_W'(8);
    localparam logic [4:0]        c_LINK_REG   = 5'd31;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend;
    logic              r_link_we;
    logic [ADDR_W-1:0] r_link_data;
    logic              r_redirect;
    logic              r_slot_err;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_adv;
    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic              w_is_j;
    logic              w_is_jal;
    logic              w_is_jr;
    logic              w_is_beq;
    logic              w_is_bne;
    logic              w_is_cf;
    logic              w_taken;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_target;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_adv   = bus.instr_valid & ~bus.stall;
    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];

    assign w_is_j   = (w_op == c_OP_J);
    assign w_is_jal = (w_op == c_OP_JAL);
    assign w_is_beq = (w_op == c_OP_BEQ);
    assign w_is_bne = (w_op == c_OP_BNE);
    assign w_is_jr  = (w_op == c_OP_SPECIAL) && (w_funct == c_FUNCT_JR);
    assign w_is_cf  = w_is_j | w_is_jal | w_is_jr | w_is_beq | w_is_bne;

    assign w_taken = w_is_j | w_is_jal | w_is_jr
                   | (w_is_beq &  bus.zero_flag)
                   | (w_is_bne & ~bus.zero_flag);

    assign w_pc_plus4   = r_pc + c_FOUR;
    assign w_branch_tgt = w_pc_plus4
                        + {{(ADDR_W-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};

    // At ADDR_W == 28 the jump target has no upper PC region to keep.
    generate
        if (ADDR_W > 28) begin : g_jump_wide
            assign w_jump_tgt = {w_pc_plus4[ADDR_W-1:28], bus.instr[25:0], 2'b00};
        end else begin : g_jump_narrow
            assign w_jump_tgt = {bus.instr[25:0], 2'b00};
        end
    endgenerate

    always_comb begin
        w_target = w_pc_plus4;
        if (w_is_jr) begin
            w_target = bus.rs_data;
        end else if (w_is_j || w_is_jal) begin
            w_target = w_jump_tgt;
        end else if (w_is_beq || w_is_bne) begin
            w_target = w_branch_tgt;
        end
    end

    assign w_cnt_next = (r_taken_cnt == {CNT_W{1'b1}}) ? r_taken_cnt
                                                       : r_taken_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_pend      <= '0;
            r_link_we   <= 1'b0;
            r_link_data <= '0;
            r_redirect  <= 1'b0;
            r_slot_err  <= 1'b0;
            r_taken_cnt <= '0;
        end else if (!w_adv) begin
            // Pulses only live for one advancing cycle; everything else holds.
            r_link_we  <= 1'b0;
            r_redirect <= 1'b0;
            r_slot_err <= 1'b0;
        end else begin
            r_link_we  <= 1'b0;
            r_redirect <= 1'b0;
            r_slot_err <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_is_jal) begin
                        r_link_we   <= 1'b1;
                        r_link_data <= (DELAY_SLOT != 0) ? (r_pc + c_EIGHT)
                                                         : (r_pc + c_FOUR);
                    end
                    if (w_taken && (DELAY_SLOT != 0)) begin
                        r_pend  <= w_target;
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_SLOT;
                    end else if (w_taken) begin
                        r_pc        <= w_target;
                        r_redirect  <= 1'b1;
                        r_taken_cnt <= w_cnt_next;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                ST_SLOT: begin
                    // Control flow in the slot is dropped and only flagged.
                    r_pc        <= r_pend;
                    r_redirect  <= 1'b1;
                    r_slot_err  <= w_is_cf;
                    r_taken_cnt <= w_cnt_next;
                    r_state     <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_plus4;
    assign bus.link_we   = r_link_we;
    assign bus.link_addr = c_LINK_REG;
    assign bus.link_data = r_link_data;
    assign bus.redirect  = r_redirect;
    assign bus.slot_err  = r_slot_err;
    assign bus.taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_control_unit
// Brief    : Directed bench for pc_control_unit in no-slot, delay-slot and
//            narrow-counter configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_control_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pc_control_unit_if #(.ADDR_W(32), .CNT_W(16)) b0 ();
    pc_control_unit_if #(.ADDR_W(32), .CNT_W(16)) b1 ();
    pc_control_unit_if #(.ADDR_W(32), .CNT_W(2))  b2 ();

    pc_control_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DELAY_SLOT(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    pc_control_unit #(.ADDR_W(32), .RESET_PC(32'h300), .DELAY_SLOT(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    pc_control_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DELAY_SLOT(0), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .bus(b2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.instr = '0; b0.instr_valid = 1'b0; b0.stall = 1'b0; b0.zero_flag = 1'b0; b0.rs_data = '0;
        b1.instr = '0; b1.instr_valid = 1'b0; b1.stall = 1'b0; b1.zero_flag = 1'b0; b1.rs_data = '0;
        b2.instr = '0; b2.instr_valid = 1'b0; b2.stall = 1'b0; b2.zero_flag = 1'b0; b2.rs_data = '0;

        #12;
        chk("rst_pc0",    b0.pc, 32'h0);
        chk("rst_pc1",    b1.pc, 32'h300);
        chk("rst_cnt0",   32'(b0.taken_cnt), 32'h0);
        chk("link_addr",  32'(b0.link_addr), 32'd31);
        reset = 1'b0;

        // ---- no delay slot ----
        b0.instr_valid = 1'b1;
        b0.instr = 32'h0800_0040;                    // J -> 0x100
        step();
        chk("j_pc",       b0.pc, 32'h100);
        chk("j_redir",    32'(b0.redirect), 32'd1);
        b0.instr = 32'h1000_FFFF; b0.zero_flag = 1'b1; // BEQ -4, taken
        step();
        chk("beq_t_pc",   b0.pc, 32'h100);
        chk("beq_t_red",  32'(b0.redirect), 32'd1);
        chk("beq_t_cnt",  32'(b0.taken_cnt), 32'd2);
        b0.zero_flag = 1'b0;                          // BEQ not taken
        step();
        chk("beq_n_pc",   b0.pc, 32'h104);
        chk("beq_n_red",  32'(b0.redirect), 32'd0);
        chk("pc_plus4",   b0.pc_plus4, 32'h108);
        b0.instr = 32'h0800_0080;                    // J -> 0x200
        step();
        chk("j2_pc",      b0.pc, 32'h200);
        b0.instr = 32'h0C00_0040;                    // JAL -> 0x100
        step();
        chk("jal_pc",     b0.pc, 32'h100);
        chk("jal_we",     32'(b0.link_we), 32'd1);
        chk("jal_data",   b0.link_data, 32'h204);
        chk("jal_cnt",    32'(b0.taken_cnt), 32'd4);
        b0.instr_valid = 1'b0;
        step();
        chk("idle_we",    32'(b0.link_we), 32'd0);
        chk("idle_pc",    b0.pc, 32'h100);
        chk("idle_data",  b0.link_data, 32'h204);
        b0.instr_valid = 1'b1;
        b0.instr = 32'h1400_0010; b0.zero_flag = 1'b0; b0.stall = 1'b1; // BNE +0x40, taken
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc",  b0.pc, 32'h100);
            chk("stall_cnt", 32'(b0.taken_cnt), 32'd4);
            chk("stall_red", 32'(b0.redirect), 32'd0);
        end
        b0.stall = 1'b0;
        step();
        chk("rel_pc",     b0.pc, 32'h144);
        chk("rel_cnt",    32'(b0.taken_cnt), 32'd5);
        chk("rel_red",    32'(b0.redirect), 32'd1);
        b0.instr_valid = 1'b0;

        // ---- delay slot ----
        b1.instr_valid = 1'b1;
        b1.instr = 32'h0800_0140;                    // J -> 0x500
        step();
        chk("ds_j_pc",    b1.pc, 32'h304);
        chk("ds_j_red",   32'(b1.redirect), 32'd0);
        b1.instr = 32'h1400_0008; b1.zero_flag = 1'b0; // BNE in slot, ignored
        step();
        chk("ds_slot_pc", b1.pc, 32'h500);
        chk("ds_slot_rd", 32'(b1.redirect), 32'd1);
        chk("ds_slot_er", 32'(b1.slot_err), 32'd1);
        chk("ds_slot_cn", 32'(b1.taken_cnt), 32'd1);
        b1.instr = 32'h0000_0000;                    // NOP
        step();
        chk("ds_nop_pc",  b1.pc, 32'h504);
        chk("ds_nop_er",  32'(b1.slot_err), 32'd0);
        b1.instr = 32'h0C00_0100;                    // JAL -> 0x400
        step();
        chk("ds_jal_pc",  b1.pc, 32'h508);
        chk("ds_jal_we",  32'(b1.link_we), 32'd1);
        chk("ds_jal_dat", b1.link_data, 32'h50C);
        b1.instr = 32'h0000_0000; b1.stall = 1'b1;
        step();
        chk("ds_stl_pc",  b1.pc, 32'h508);
        chk("ds_stl_we",  32'(b1.link_we), 32'd0);
        b1.stall = 1'b0;
        step();
        chk("ds_rel_pc",  b1.pc, 32'h400);
        chk("ds_rel_red", 32'(b1.redirect), 32'd1);
        chk("ds_rel_cnt", 32'(b1.taken_cnt), 32'd2);
        b1.instr_valid = 1'b0;

        // ---- saturating counter, JR wrap ----
        b2.instr_valid = 1'b1;
        b2.instr = 32'h0800_0010;                    // J -> 0x40
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_cnt", 32'(b2.taken_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        b2.instr = 32'h0000_0008; b2.rs_data = 32'hFFFF_FFFC; // JR
        step();
        chk("jr_pc",      b2.pc, 32'hFFFF_FFFC);
        chk("jr_plus4",   b2.pc_plus4, 32'h0);
        chk("jr_cnt",     32'(b2.taken_cnt), 32'd3);
        b2.instr_valid = 1'b0;

        // ---- asynchronous reset mid-cycle ----
        b0.instr_valid = 1'b1;
        b0.instr = 32'h0800_0010;                    // J -> 0x40
        step();
        chk("pre_rst_pc", b0.pc, 32'h40);
        b0.instr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc",    b0.pc, 32'h0);
        chk("arst_red",   32'(b0.redirect), 32'd0);
        chk("arst_we",    32'(b0.link_we), 32'd0);
        chk("arst_serr",  32'(b0.slot_err), 32'd0);
        chk("arst_cnt",   32'(b0.taken_cnt), 32'd0);
        chk("arst_pc1",   b1.pc, 32'h300);
        chk("arst_pc2",   b2.pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
